// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single RAM8 (8 x 16-bit).
// IDLE -> ACCESS (one RAM cycle) -> RESP (done pulse) -> IDLE.
module ram8_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  addr0,
    input  logic [2:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        ram_load,
    output logic [2:0]  ram_address,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state, state_next;
    logic        last;
    logic        owner;
    logic        we_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        grant;
    logic        grant_port;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All outputs decode from state and registers only; req inputs affect only next state.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        busy       = 1'b0;
        ram_load   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    grant_port = (req0 && req1) ? ~last : req1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy       = 1'b1;
                ram_load   = we_q;
                state_next = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                done0      = ~owner;
                done1      = owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_address = addr_q;
    assign ram_in      = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (grant) begin
                owner   <= grant_port;
                last    <= grant_port;
                we_q    <= grant_port ? we1 : we0;
                addr_q  <= grant_port ? addr1 : addr0;
                wdata_q <= grant_port ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                if (owner) begin
                    rdata1 <= we_q ? wdata_q : ram_out;
                end else begin
                    rdata0 <= we_q ? wdata_q : ram_out;
                end
            end
        end
    end

endmodule

// File: doc/ram8_arbiter.md
# ram8_arbiter

Two-port round-robin arbiter and sequencer for a single RAM8 (8 × 16-bit, synchronous write on `load`, combinational read of `out`). Two requesters issue read or write transactions with a req/done handshake. The arbiter picks one, drives the RAM8 `load`/`address`/`in` pins for exactly one access cycle, and returns a registered result with a one-cycle done pulse. It sits between the RAM8 instance and any pair of masters, such as a CPU data port and a loader/debug port.

## Interface
- No parameters. Data width is fixed at 16 and address width at 3 to match RAM8.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: transaction request from port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in 3: word address.
- `wdata0`, `wdata1` in 16: write data.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out 16: registered result per port.
- `busy` out 1: high whenever state ≠ IDLE.
- `ram_load` out 1: drives RAM8 `load`.
- `ram_address` out 3: drives RAM8 `address`.
- `ram_in` out 16: drives RAM8 `in`.
- `ram_out` in 16: RAM8 `out`.

## Operation
- The FSM has three states: IDLE → ACCESS → RESP → IDLE. It never skips a state and has no other transitions.
- **IDLE:**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port ≠ `last` wins. `last` is the 1-bit owner of the most recently granted transaction.
  - On the edge where a grant occurs, latch owner, we, addr and wdata into internal registers, update `last` to the owner, and go to ACCESS.
- **ACCESS:**
  - `ram_address` = latched addr and `ram_in` = latched wdata.
  - `ram_load` = latched we. It is high only in this state.
  - At the closing edge, RAM8 performs the write (if we) and the owner's rdata register loads:
    - read: `ram_out`;
    - write: the latched wdata.
  - Go to RESP.
- **RESP:**
  - The owner's done is high for this one cycle; the other done stays 0.
  - Go to IDLE unconditionally.
- **Handshake rules:**
  - The requester holds we/addr/wdata stable from raising req until the edge at which it samples done = 1.
  - A req still high in IDLE after that edge is treated as a new transaction.
  - Req is sampled only in IDLE. Req changes in ACCESS/RESP are ignored.
- **rdata:**
  - `rdataN` changes only at the ACCESS→RESP edge of a port-N transaction.
  - Otherwise it holds its value indefinitely, including across the other port's transactions.
- **RAM pins outside ACCESS:**
  - `ram_load` = 0.
  - `ram_address` and `ram_in` keep showing the latched registers. They have no functional meaning outside ACCESS.
- **Fairness:** with both ports continuously requesting, grants alternate 0,1,0,1… Neither port waits more than one other transaction.

## Timing
- **Reset** asynchronously forces:
  - state = IDLE and `last` = 1, so port 0 wins the first tie;
  - latched we/addr/wdata = 0 and `rdata0` = `rdata1` = 0;
  - `done0`/`done1`/`busy`/`ram_load` = 0, and `ram_address` = 0, `ram_in` = 0.
- **Reset mid-transaction:**
  - The transaction is aborted and no done is issued.
  - If reset asserts during ACCESS, `ram_load` falls immediately (it is decoded from state), so no RAM write occurs at the following edge.
  - RAM8 contents are not cleared.
- **Latency:**
  - Req is sampled high at IDLE edge k.
  - ACCESS occupies cycle k..k+1 (`ram_load` high for a write).
  - done is high in cycle k+1..k+2, and rdata is valid from edge k+1 onward.
  - The requester sees done at edge k+2.
- **Throughput:** one transaction per 3 cycles, shared across both ports.
- **Outputs are registered or decoded from state only.** No combinational path from any req/we/addr/wdata input to any output.

## Test plan
- **Reset:** hold `reset`=1 with random inputs → all outputs 0 and `busy`=0. Assert `reset` asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- **Write then read on one port:**
  - Port 0 writes addr 3 with 0x00FF → `ram_load`=1 for exactly one cycle with `ram_address`=3 and `ram_in`=0x00FF. `done0` pulses 2 cycles after the sample edge and `rdata0`=0x00FF.
  - Then port 1 reads addr 3 → `ram_load` stays 0, `done1` pulses and `rdata1`=0x00FF. `rdata0` is unchanged.
- **Simultaneous requests after reset:** port 0 writes 0xF0F0 to addr 2 while port 1 reads addr 2 in the same cycle → port 0 is served first. `done1` pulses 3 cycles after `done0` and `rdata1`=0xF0F0.
- **Fairness:** both ports hold req continuously for 12 transactions → done pulses alternate 0,1,0,1…, exactly 3 cycles apart. Neither port gets two consecutive grants.
- **Back-to-back single port:** port 1 reads addresses 0..7 with req held high, changing addr on each done → 8 done1 pulses spaced 3 cycles apart, with `rdata1` matching the preloaded RAM contents.
- **Reset during write:**
  - Preload addr 5 = 0x1234.
  - Port 0 writes 0xAAAA to addr 5, and `reset` pulses during ACCESS → no `done0`, and `ram_load` is 0 at the edge.
  - A later read of addr 5 returns 0x1234.
